// File: rtl/div_issue_ctrl.sv
// Issue/response controller for the 64-bit iterative divider: operand prep, RISC-V special cases, flush/drain.
// Optional one-entry result cache, enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            div_valid,
  input  logic            div_ready,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_signed,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic            op_signed_q, op_rem_q, op_word_q;
  logic [XLEN-1:0] dividend_q, divisor_q, resp_data_q;
  logic            req_signed, accept, capture;
  logic            is_dz, is_ovf, special, cache_hit, fast_path;
  logic [XLEN-1:0] prep_a, prep_b, min_neg;
  logic [XLEN-1:0] fast_q, fast_r, fast_sel, fast_data;
  logic [XLEN-1:0] cache_q, cache_r, div_sel, div_data;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  assign req_signed = ~req_op[0];
  assign accept     = req_valid & req_ready & ~flush;
  assign capture    = (state == S_WAIT) & div_out_valid & ~flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    prep_a = req_src1;
    prep_b = req_src2;
    if (req_word) begin
      prep_a = req_signed ? sext32(req_src1[31:0]) : {{(XLEN-32){1'b0}}, req_src1[31:0]};
      prep_b = req_signed ? sext32(req_src2[31:0]) : {{(XLEN-32){1'b0}}, req_src2[31:0]};
    end
  end

  // Most negative value of the op width, as it appears after preparation.
  assign min_neg   = req_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign is_dz     = (prep_b == '0);
  assign is_ovf    = req_signed & (prep_a == min_neg) & (prep_b == '1);
  assign special   = is_dz | is_ovf;
  assign fast_path = special | cache_hit;

  always_comb begin
    fast_q = cache_q;
    fast_r = cache_r;
    if (is_dz) begin
      fast_q = '1;
      fast_r = prep_a;
    end else if (is_ovf) begin
      fast_q = prep_a;
      fast_r = '0;
    end
  end

  assign fast_sel  = req_op[1] ? fast_r : fast_q;
  assign fast_data = req_word ? sext32(fast_sel[31:0]) : fast_sel;
  assign div_sel   = op_rem_q ? div_remainder : div_quotient;
  assign div_data  = op_word_q ? sext32(div_sel[31:0]) : div_sel;

`ifdef DIV_RESULT_CACHE_EN
  logic            c_valid, c_signed, c_word;
  logic [XLEN-1:0] c_dividend, c_divisor, c_quot, c_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       c_valid <= 1'b0;
    else if (capture) c_valid <= 1'b1;
  end

  // NOTE: the payload is not reset; c_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (capture) begin
      c_dividend <= dividend_q;
      c_divisor  <= divisor_q;
      c_signed   <= op_signed_q;
      c_word     <= op_word_q;
      c_quot     <= div_quotient;
      c_rem      <= div_remainder;
    end
  end

  assign cache_hit = c_valid & (c_dividend == prep_a) & (c_divisor == prep_b) &
                     (c_signed == req_signed) & (c_word == req_word);
  assign cache_q   = c_quot;
  assign cache_r   = c_rem;
`else
  assign cache_hit = 1'b0;
  assign cache_q   = '0;
  assign cache_r   = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Flush outranks every other transition; the divider cannot abort, so an issued op is drained.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = fast_path ? S_RESP : S_ISSUE;
      S_ISSUE: if (flush)          state_nxt = div_ready ? S_DRAIN : S_IDLE;
               else if (div_ready) state_nxt = S_WAIT;
      S_WAIT:  if (flush)              state_nxt = div_out_valid ? S_IDLE : S_DRAIN;
               else if (div_out_valid) state_nxt = S_RESP;
      S_RESP:  if (flush || resp_ready) state_nxt = S_IDLE;
      S_DRAIN: if (div_out_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    div_valid  = (state == S_ISSUE);
    resp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_signed_q <= 1'b0;
      op_rem_q    <= 1'b0;
      op_word_q   <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      op_signed_q <= req_signed;
      op_rem_q    <= req_op[1];
      op_word_q   <= req_word;
      dividend_q  <= prep_a;
      divisor_q   <= prep_b;
      if (fast_path) resp_data_q <= fast_data;
    end else if (capture) begin
      resp_data_q <= div_data;
    end
  end

  assign resp_data    = resp_data_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign div_signed   = op_signed_q;

endmodule
